if_fetch: RTL

Instruction-fetch front end that drives the IF/ID pipeline register. It owns the program counter and issues one instruction-memory request at a time over a ready/valid handshake. It presents each returned word with its PC to the IF/ID stage, holding it while the pipeline stalls and discarding it on a branch/jump redirect.

---
 rtl/if_fetch.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/if_fetch.sv
// if_fetch: instruction-fetch front end driving the IF/ID register.
// Ports: clk, rst (async, active-low), stall_i, redirect_i, redirect_pc_i,
// mem_req_o/mem_addr_o/mem_ready_i, mem_rvalid_i/mem_rdata_i,
// if_pc/if_inst/if_valid. Define FETCH_PERF_CNT_EN to add fetch_cnt_o
// and squash_cnt_o.
module if_fetch #(
  parameter int ADDR_W = 32,
  parameter int INST_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_ready_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  output logic [ADDR_W-1:0] if_pc,
  output logic [INST_W-1:0] if_inst,
  output logic              if_valid
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt_o,
  output logic [31:0]       squash_cnt_o
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    HOLD
  } state_t;

  localparam logic [ADDR_W-1:0] ALIGN =
    ~ADDR_W'(3);

  state_t state, state_n;

  logic [ADDR_W-1:0] pc, pc_n, pc_inc;
  logic [ADDR_W-1:0] buf_pc, buf_pc_n;
  logic [INST_W-1:0] buf_inst, buf_inst_n;
  logic [ADDR_W-1:0] if_pc_n;
  logic [INST_W-1:0] if_inst_n;
  logic              if_valid_n;
  logic              kill, kill_n;
  logic              load;
  logic              free;

  assign pc_inc = pc + ADDR_W'(4);
  assign free   = !if_valid || !stall_i;

  // Request is suppressed while reset is held.
  assign mem_req_o  = rst && (state == IDLE);
  assign mem_addr_o = pc & ALIGN;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      kill     <= 1'b0;
      buf_pc   <= '0;
      buf_inst <= '0;
      if_pc    <= '0;
      if_inst  <= '0;
      if_valid <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      kill     <= kill_n;
      buf_pc   <= buf_pc_n;
      buf_inst <= buf_inst_n;
      if_pc    <= if_pc_n;
      if_inst  <= if_inst_n;
      if_valid <= if_valid_n;
    end
  end

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    kill_n     = kill;
    buf_pc_n   = buf_pc;
    buf_inst_n = buf_inst;
    if_pc_n    = if_pc;
    if_inst_n  = if_inst;
    // A presented word is consumed on any non-stalled cycle.
    if_valid_n = if_valid && stall_i;
    load       = 1'b0;

    if (redirect_i) begin
      if_valid_n = 1'b0;
      pc_n       = redirect_pc_i & ALIGN;
      unique case (state)
        IDLE: begin
          // Old-address request still goes out; its reply is dropped.
          if (mem_ready_i) begin
            state_n = WAIT;
            kill_n  = 1'b1;
          end
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            state_n = IDLE;
            kill_n  = 1'b0;
          end else begin
            kill_n  = 1'b1;
          end
        end
        HOLD: state_n = IDLE;
        default: state_n = IDLE;
      endcase
    end else begin
      unique case (state)
        IDLE: begin
          if (mem_ready_i) state_n = WAIT;
        end
        WAIT: begin
          if (mem_rvalid_i) begin
            if (kill) begin
              kill_n  = 1'b0;
              state_n = IDLE;
            end else if (free) begin
              if_pc_n   = pc;
              if_inst_n = mem_rdata_i;
              load      = 1'b1;
              pc_n      = pc_inc;
              state_n   = IDLE;
            end else begin
              buf_pc_n   = pc;
              buf_inst_n = mem_rdata_i;
              state_n    = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            if_pc_n   = buf_pc;
            if_inst_n = buf_inst;
            load      = 1'b1;
            pc_n      = pc_inc;
            state_n   = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
      if (load) if_valid_n = 1'b1;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [1:0] squash;

  // HOLD and WAIT are exclusive, so at most two drops per cycle.
  always_comb begin
    squash = 2'd0;
    if (redirect_i && if_valid)
      squash = squash + 2'd1;
    if (redirect_i && state == HOLD)
      squash = squash + 2'd1;
    if (state == WAIT && mem_rvalid_i &&
        (redirect_i || kill))
      squash = squash + 2'd1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_cnt_o  <= '0;
      squash_cnt_o <= '0;
    end else begin
      if (load)
        fetch_cnt_o <= fetch_cnt_o + 32'd1;
      squash_cnt_o <= squash_cnt_o + 32'(squash);
    end
  end
`endif

endmodule
